sgdmac_axi_mem_slave: RTL

SGDMAC_AXI_MEM_SLAVE -- requirements
Module: sgdmac_axi_mem_slave

---
 rtl/sgdmac_axi_mem_slave.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/sgdmac_axi_mem_slave.sv
// AXI3 slave backed by a 2^MEM_AW x 32-bit word memory.
// Independent write and read engines, each with one outstanding INCR burst.
module sgdmac_axi_mem_slave #(
  parameter int unsigned MEM_AW = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  // Write address
  input  logic [3:0]  awid_i,
  input  logic [31:0] awaddr_i,
  input  logic [3:0]  awlen_i,
  input  logic [2:0]  awsize_i,
  input  logic [1:0]  awburst_i,
  input  logic        awvalid_i,
  output logic        awready_o,
  // Write data
  input  logic [3:0]  wid_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  wstrb_i,
  input  logic        wlast_i,
  input  logic        wvalid_i,
  output logic        wready_o,
  // Write response
  output logic [3:0]  bid_o,
  output logic [1:0]  bresp_o,
  output logic        bvalid_o,
  input  logic        bready_i,
  // Read address
  input  logic [3:0]  arid_i,
  input  logic [31:0] araddr_i,
  input  logic [3:0]  arlen_i,
  input  logic [2:0]  arsize_i,
  input  logic [1:0]  arburst_i,
  input  logic        arvalid_i,
  output logic        arready_o,
  // Read data
  output logic [3:0]  rid_o,
  output logic [31:0] rdata_o,
  output logic [1:0]  rresp_o,
  output logic        rlast_o,
  output logic        rvalid_o,
  input  logic        rready_i
);

  localparam int unsigned Depth = 2 ** MEM_AW;

  typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;
  typedef enum logic {RIdle, RData} r_state_e;

  logic [31:0] mem [Depth];

  // AXI3 write interleaving is not supported, so the W channel ID is ignored.
  logic unused_wid;
  assign unused_wid = ^wid_i;

  // ---------------------------------------------------------------------------
  // Write engine
  // ---------------------------------------------------------------------------
  w_state_e    w_state_q, w_state_d;
  logic [3:0]  w_id_q;
  logic [31:0] w_addr_q;
  logic [3:0]  w_len_q;
  logic [3:0]  w_cnt_q;
  logic        w_bad_q;
  logic        w_err_q;

  logic              aw_hs, w_hs, w_last_beat, w_oor, w_last_bad, mem_we;
  logic [MEM_AW-1:0] w_idx;

  assign aw_hs       = awvalid_i & awready_o;
  assign w_hs        = wvalid_i & wready_o;
  assign w_last_beat = (w_cnt_q == w_len_q);
  assign w_oor       = |(w_addr_q >> (MEM_AW + 2));
  assign w_last_bad  = (wlast_i != w_last_beat);
  assign w_idx       = w_addr_q[MEM_AW+1:2];
  // Bad-burst or out-of-range beats are consumed but never touch memory.
  assign mem_we      = w_hs & ~w_oor & ~w_bad_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state_q <= WIdle;
    end else begin
      w_state_q <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = w_state_q;
    case (w_state_q)
      WIdle:   if (awvalid_i) w_state_d = WData;
      WData:   if (wvalid_i && w_last_beat) w_state_d = WResp;
      WResp:   if (bready_i) w_state_d = WIdle;
      default: w_state_d = WIdle;
    endcase
  end

  always_comb begin
    awready_o = (w_state_q == WIdle);
    wready_o  = (w_state_q == WData);
    bvalid_o  = (w_state_q == WResp);
    bid_o     = w_id_q;
    bresp_o   = (bvalid_o && w_err_q) ? 2'b10 : 2'b00;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_id_q   <= '0;
      w_addr_q <= '0;
      w_len_q  <= '0;
      w_cnt_q  <= '0;
      w_bad_q  <= 1'b0;
      w_err_q  <= 1'b0;
    end else if (aw_hs) begin
      w_id_q   <= awid_i;
      w_addr_q <= awaddr_i;
      w_len_q  <= awlen_i;
      w_cnt_q  <= '0;
      w_bad_q  <= (awburst_i != 2'b01) || (awsize_i != 3'b010);
      w_err_q  <= (awburst_i != 2'b01) || (awsize_i != 3'b010);
    end else if (w_hs) begin
      w_addr_q <= w_addr_q + 32'd4;
      w_cnt_q  <= w_cnt_q + 4'd1;
      w_err_q  <= w_err_q | w_oor | w_last_bad;
    end
  end

  // Memory is intentionally not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb_i[b]) mem[w_idx][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read engine
  // ---------------------------------------------------------------------------
  r_state_e    r_state_q, r_state_d;
  logic [3:0]  r_id_q;
  logic [31:0] r_addr_q;
  logic [3:0]  r_len_q;
  logic [3:0]  r_cnt_q;
  logic        r_bad_q;

  logic              ar_hs, r_hs, r_last_beat, r_oor, r_err_beat;
  logic [MEM_AW-1:0] r_idx;

  assign ar_hs       = arvalid_i & arready_o;
  assign r_hs        = rvalid_o & rready_i;
  assign r_last_beat = (r_cnt_q == r_len_q);
  assign r_oor       = |(r_addr_q >> (MEM_AW + 2));
  assign r_err_beat  = r_oor | r_bad_q;
  assign r_idx       = r_addr_q[MEM_AW+1:2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state_q <= RIdle;
    end else begin
      r_state_q <= r_state_d;
    end
  end

  always_comb begin
    r_state_d = r_state_q;
    case (r_state_q)
      RIdle:   if (arvalid_i) r_state_d = RData;
      RData:   if (rready_i && r_last_beat) r_state_d = RIdle;
      default: r_state_d = RIdle;
    endcase
  end

  // Combinational array read: a same-cycle write to this word lands after the edge.
  always_comb begin
    arready_o = (r_state_q == RIdle);
    rvalid_o  = (r_state_q == RData);
    rid_o     = r_id_q;
    rlast_o   = rvalid_o & r_last_beat;
    rresp_o   = (rvalid_o && r_err_beat) ? 2'b10 : 2'b00;
    rdata_o   = (rvalid_o && !r_err_beat) ? mem[r_idx] : 32'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_id_q   <= '0;
      r_addr_q <= '0;
      r_len_q  <= '0;
      r_cnt_q  <= '0;
      r_bad_q  <= 1'b0;
    end else if (ar_hs) begin
      r_id_q   <= arid_i;
      r_addr_q <= araddr_i;
      r_len_q  <= arlen_i;
      r_cnt_q  <= '0;
      r_bad_q  <= (arburst_i != 2'b01) || (arsize_i != 3'b010);
    end else if (r_hs) begin
      r_addr_q <= r_addr_q + 32'd4;
      r_cnt_q  <= r_cnt_q + 4'd1;
    end
  end

endmodule
